// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NREAD = 2;

  // Clear sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

  // Bit offset of port p's field inside a packed bus of w-bit fields.
  function automatic int port_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks the array one entry per cycle, exposes Busy,
// gates writes while sweeping and flags rejected writes.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_clear_req,
  input  logic              i_reg_write,
  output logic              o_busy,
  output logic              o_write_dropped,
  output logic              o_clr_en,
  output logic [ADDR_W-1:0] o_clr_idx,
  output logic              o_wr_allow
);

  // Entry 0 is never swept when it is hard-wired to zero.
  localparam logic [ADDR_W:0] FIRST = (ADDR_W+1)'((ZERO_REG != 0) ? 1 : 0);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  clr_state_t      r_state;
  logic [ADDR_W:0] r_idx;   // one spare bit so the counter never wraps
  logic            r_busy;
  logic            r_wdrop;

  // FSM, index counter and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_wdrop <= 1'b0;
    end else begin
      r_wdrop <= (r_state == SWEEP) && i_reg_write;
      case (r_state)
        IDLE: begin
          if (i_clear_req) begin
            r_state <= SWEEP;
            r_idx   <= FIRST;
            r_busy  <= 1'b1;
          end
        end
        SWEEP: begin
          // Further clear requests are ignored; the sweep never restarts.
          if (r_idx == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_write_dropped = r_wdrop;
  assign o_clr_en        = (r_state == SWEEP);
  assign o_clr_idx       = r_idx[ADDR_W-1:0];
  assign o_wr_allow      = (r_state == IDLE);

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NREAD combinational read ports, one write
// port, optional write-to-read bypass, optional hard-wired zero register
// and a runtime clear sweep.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       WriteRegister,
  input  logic [WIDTH-1:0]        WriteData,
  input  logic [NREAD*ADDR_W-1:0] ReadRegister,
  output logic [NREAD*WIDTH-1:0]  ReadData,
  input  logic                    ClearReq,
  output logic                    Busy,
  output logic                    WriteDropped
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_wr_allow;
  logic              w_wr_en;

  regfile_clear_seq #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_clr (
    .Clk             (Clk),
    .Reset           (Reset),
    .i_clear_req     (ClearReq),
    .i_reg_write     (RegWrite),
    .o_busy          (Busy),
    .o_write_dropped (WriteDropped),
    .o_clr_en        (w_clr_en),
    .o_clr_idx       (w_clr_idx),
    .o_wr_allow      (w_wr_allow)
  );

  // A write to the hard-wired zero register is discarded silently.
  assign w_wr_en = RegWrite && w_wr_allow && !(ZR && (WriteRegister == '0));

  // Storage: reset, sweep clear, or single-entry write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clr_en) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[WriteRegister] <= WriteData;
    end
  end

  // Independent combinational read muxes, each with its own bypass check.
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    localparam int AL = port_lsb(p, ADDR_W);
    localparam int DL = port_lsb(p, WIDTH);

    logic [ADDR_W-1:0] w_raddr;
    logic              w_zero;
    logic              w_hit;

    assign w_raddr = ReadRegister[AL +: ADDR_W];
    assign w_zero  = ZR && (w_raddr == '0);
    // w_wr_en is already false during a sweep, which disables bypass there.
    assign w_hit   = BP && w_wr_en && (w_raddr == WriteRegister);
    assign ReadData[DL +: WIDTH] = w_zero ? '0 :
                                   w_hit  ? WriteData : r_mem[w_raddr];
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: default config, a no-zero/bypass config and a 4-port
// 16x8 config sharing one clock and reset.
module tb_regfile_multiport;

  logic Clk = 1'b0;
  logic rst;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Default instance: 32x32, 2 read ports, ZERO_REG=1, BYPASS=0
  logic        d_rw, d_clr, d_busy, d_wdrop;
  logic [4:0]  d_wa;
  logic [31:0] d_wd;
  logic [9:0]  d_ra;
  logic [63:0] d_rd;

  // Alternate instance: ZERO_REG=0, BYPASS=1
  logic        a_rw, a_clr, a_busy, a_wdrop;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;

  // Wide instance: NREAD=4, WIDTH=16, DEPTH=8
  logic        w_rw, w_clr, w_busy, w_wdrop;
  logic [2:0]  w_wa;
  logic [15:0] w_wd;
  logic [11:0] w_ra;
  logic [63:0] w_rd;

  regfile_multiport u_def (
    .Clk(Clk), .Reset(rst), .RegWrite(d_rw), .WriteRegister(d_wa),
    .WriteData(d_wd), .ReadRegister(d_ra), .ReadData(d_rd),
    .ClearReq(d_clr), .Busy(d_busy), .WriteDropped(d_wdrop)
  );

  regfile_multiport #(.ZERO_REG(0), .BYPASS(1)) u_alt (
    .Clk(Clk), .Reset(rst), .RegWrite(a_rw), .WriteRegister(a_wa),
    .WriteData(a_wd), .ReadRegister(a_ra), .ReadData(a_rd),
    .ClearReq(a_clr), .Busy(a_busy), .WriteDropped(a_wdrop)
  );

  regfile_multiport #(.WIDTH(16), .DEPTH(8), .NREAD(4)) u_wide (
    .Clk(Clk), .Reset(rst), .RegWrite(w_rw), .WriteRegister(w_wa),
    .WriteData(w_wd), .ReadRegister(w_ra), .ReadData(w_rd),
    .ClearReq(w_clr), .Busy(w_busy), .WriteDropped(w_wdrop)
  );

  task automatic d_wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge Clk); d_rw = 1'b1; d_wa = a; d_wd = v;
    @(negedge Clk); d_rw = 1'b0;
  endtask

  task automatic a_wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge Clk); a_rw = 1'b1; a_wa = a; a_wd = v;
    @(negedge Clk); a_rw = 1'b0;
  endtask

  task automatic w_wr(input logic [2:0] a, input logic [15:0] v);
    @(negedge Clk); w_rw = 1'b1; w_wa = a; w_wd = v;
    @(negedge Clk); w_rw = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge Clk);
    d_ra = {5'd31, 5'd5}; #1;
    checks++;
    if (d_rd !== 64'd0) begin
      failures++; $display("FAIL reset_regs got=%h want=0", d_rd);
    end
    checks++;
    if ({d_busy, d_wdrop, a_busy, w_busy} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_status got=%b want=0000", {d_busy, d_wdrop, a_busy, w_busy});
    end
    @(negedge Clk); rst = 1'b0;
  endtask

  task automatic test_rw_ports;
    d_wr(5'd2, 32'd42);
    d_ra = {5'd2, 5'd2}; #1;
    checks++;
    if (d_rd !== {32'd42, 32'd42}) begin
      failures++; $display("FAIL rw_42 got=%h want=%h", d_rd, {32'd42, 32'd42});
    end
    d_wr(5'd2, 32'd15); #1;
    checks++;
    if (d_rd !== {32'd15, 32'd15}) begin
      failures++; $display("FAIL rw_15 got=%h want=%h", d_rd, {32'd15, 32'd15});
    end
    d_wr(5'd17, 32'd17);
    d_wr(5'd9, 32'd99);
    d_ra = {5'd17, 5'd9}; #1;
    checks++;
    if (d_rd !== {32'd17, 32'd99}) begin
      failures++; $display("FAIL ports_9_17 got=%h want=%h", d_rd, {32'd17, 32'd99});
    end
    d_ra = {5'd9, 5'd17}; #1;
    checks++;
    if (d_rd !== {32'd99, 32'd17}) begin
      failures++; $display("FAIL ports_swap got=%h want=%h", d_rd, {32'd99, 32'd17});
    end
  endtask

  task automatic test_enable_decode;
    d_wr(5'd3, 32'd7);
    @(negedge Clk); d_rw = 1'b0; d_wa = 5'd3; d_wd = 32'd26;
    @(negedge Clk);
    d_ra = {5'd3, 5'd3}; #1;
    checks++;
    if (d_rd !== {32'd7, 32'd7}) begin
      failures++; $display("FAIL enable_off got=%h want=%h", d_rd, {32'd7, 32'd7});
    end
    d_wr(5'd5, 32'd5);
    d_wr(5'd4, 32'd23);
    d_ra = {5'd5, 5'd4}; #1;
    checks++;
    if (d_rd !== {32'd5, 32'd23}) begin
      failures++; $display("FAIL decode_4_5 got=%h want=%h", d_rd, {32'd5, 32'd23});
    end
    d_ra = {5'd31, 5'd31}; #1;
    checks++;
    if (d_rd !== 64'd0) begin
      failures++; $display("FAIL decode_r31 got=%h want=0", d_rd);
    end
  endtask

  task automatic test_zero_reg;
    d_wr(5'd0, 32'd19);
    d_ra = {5'd0, 5'd0}; #1;
    checks++;
    if (d_rd !== 64'd0) begin
      failures++; $display("FAIL zero_reg_read got=%h want=0", d_rd);
    end
    checks++;
    if (d_wdrop !== 1'b0) begin
      failures++; $display("FAIL zero_reg_wdrop got=%b want=0", d_wdrop);
    end
    a_wr(5'd0, 32'd19);
    a_ra = {5'd0, 5'd0}; #1;
    checks++;
    if (a_rd !== {32'd19, 32'd19}) begin
      failures++; $display("FAIL no_zero_reg got=%h want=%h", a_rd, {32'd19, 32'd19});
    end
  endtask

  task automatic test_bypass;
    a_wr(5'd6, 32'd1);
    @(negedge Clk);
    a_rw = 1'b1; a_wa = 5'd6; a_wd = 32'h0000ABCD; a_ra = {5'd0, 5'd6}; #1;
    checks++;
    if (a_rd !== {32'd19, 32'h0000ABCD}) begin
      failures++; $display("FAIL bypass_on got=%h want=%h", a_rd, {32'd19, 32'h0000ABCD});
    end
    @(negedge Clk); a_rw = 1'b0;
    d_wr(5'd6, 32'd1);
    @(negedge Clk);
    d_rw = 1'b1; d_wa = 5'd6; d_wd = 32'h0000ABCD; d_ra = {5'd6, 5'd6}; #1;
    checks++;
    if (d_rd !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL bypass_off_pre got=%h want=%h", d_rd, {32'd1, 32'd1});
    end
    @(negedge Clk); d_rw = 1'b0; #1;
    checks++;
    if (d_rd !== {32'h0000ABCD, 32'h0000ABCD}) begin
      failures++; $display("FAIL bypass_off_post got=%h want=0000abcd x2", d_rd);
    end
  endtask

  task automatic test_wide;
    w_wr(3'd7, 16'hFFFF);
    w_ra = {3'd7, 3'd7, 3'd7, 3'd7}; #1;
    checks++;
    if (w_rd !== {4{16'hFFFF}}) begin
      failures++; $display("FAIL wide_all7 got=%h want=%h", w_rd, {4{16'hFFFF}});
    end
    w_ra = {3'd7, 3'd3, 3'd7, 3'd3}; #1;
    checks++;
    if (w_rd !== {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}) begin
      failures++; $display("FAIL wide_mixed got=%h want=ffff0000ffff0000", w_rd);
    end
  endtask

  task automatic test_clear_sweep;
    int busy_cnt;
    for (int i = 1; i < 32; i++) d_wr(5'(i), 32'(i));
    d_ra = {5'd31, 5'd1}; #1;
    checks++;
    if (d_rd !== {32'd31, 32'd1}) begin
      failures++; $display("FAIL fill got=%h want=%h", d_rd, {32'd31, 32'd1});
    end
    @(negedge Clk); d_clr = 1'b1;
    @(negedge Clk); d_clr = 1'b0;
    busy_cnt = 0;
    while (d_busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 5) begin
        checks++;
        if (d_wdrop !== 1'b0) begin
          failures++; $display("FAIL wdrop_idle got=%b want=0", d_wdrop);
        end
      end
      if (busy_cnt == 6) begin
        checks++;
        if (d_wdrop !== 1'b1) begin
          failures++; $display("FAIL wdrop_pulse got=%b want=1", d_wdrop);
        end
      end
      if (busy_cnt == 7) begin
        checks++;
        if (d_wdrop !== 1'b0) begin
          failures++; $display("FAIL wdrop_width got=%b want=0", d_wdrop);
        end
      end
      if (busy_cnt == 10) begin
        // entries 1..9 already cleared, entry 10 not yet
        d_ra = {5'd10, 5'd9}; #1;
        checks++;
        if (d_rd !== {32'd10, 32'd0}) begin
          failures++; $display("FAIL partial_clear got=%h want=%h", d_rd, {32'd10, 32'd0});
        end
      end
      if (busy_cnt == 5) begin
        d_rw = 1'b1; d_wa = 5'd8; d_wd = 32'd55; d_clr = 1'b1;
      end else begin
        d_rw = 1'b0; d_clr = 1'b0;
      end
      @(negedge Clk);
    end
    checks++;
    if (busy_cnt != 31) begin
      failures++; $display("FAIL sweep_len got=%0d want=31", busy_cnt);
    end
    for (int a = 0; a < 32; a += 2) begin
      d_ra = {5'(a + 1), 5'(a)}; #1;
      checks++;
      if (d_rd !== 64'd0) begin
        failures++; $display("FAIL cleared r%0d/r%0d got=%h want=0", a, a + 1, d_rd);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    d_wr(5'd20, 32'd20);
    d_wr(5'd21, 32'd21);
    @(negedge Clk); d_clr = 1'b1;
    @(negedge Clk); d_clr = 1'b0;
    repeat (9) @(negedge Clk);
    d_ra = {5'd21, 5'd20}; #1;
    checks++;
    if (d_busy !== 1'b1 || d_rd !== {32'd21, 32'd20}) begin
      failures++; $display("FAIL pre_abort busy=%b got=%h want busy=1 %h", d_busy, d_rd, {32'd21, 32'd20});
    end
    rst = 1'b1;
    @(negedge Clk); rst = 1'b0; #1;
    checks++;
    if (d_busy !== 1'b0 || d_rd !== 64'd0) begin
      failures++; $display("FAIL abort busy=%b got=%h want busy=0 0", d_busy, d_rd);
    end
    @(negedge Clk); #1;
    checks++;
    if (d_busy !== 1'b0) begin
      failures++; $display("FAIL abort_stays_idle busy=%b want=0", d_busy);
    end
    d_wr(5'd20, 32'd3);
    d_ra = {5'd20, 5'd20}; #1;
    checks++;
    if (d_rd !== {32'd3, 32'd3}) begin
      failures++; $display("FAIL post_abort_write got=%h want=%h", d_rd, {32'd3, 32'd3});
    end
  endtask

  initial begin
    rst = 1'b1;
    d_rw = 0; d_clr = 0; d_wa = 0; d_wd = 0; d_ra = 0;
    a_rw = 0; a_clr = 0; a_wa = 0; a_wd = 0; a_ra = 0;
    w_rw = 0; w_clr = 0; w_wa = 0; w_wd = 0; w_ra = 0;
    test_reset();
    test_rw_ports();
    test_enable_decode();
    test_zero_reg();
    test_bypass();
    test_wide();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the 32x32, 2-read/1-write register file.
- Generalised in data width, depth and read-port count.
- Adds optional write-to-read bypass, configurable hard-wired register zero, and a runtime clear sequencer that zeroes the array one entry per cycle with a Busy handshake.
- Sits in the CPU datapath between decode (addresses) and execute/writeback (data).

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; power of two, at least 2. ADDR_W = $clog2(DEPTH) is a derived localparam.
- NREAD, 2, number of independent read ports, at least 1.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 register 0 is an ordinary register.
- BYPASS, 0, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable.
- WriteRegister  input  ADDR_W  write address.
- WriteData  input  WIDTH  write data.
- ReadRegister  input  NREAD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- ReadData  output  NREAD*WIDTH  packed read data; port p uses bits [p*WIDTH +: WIDTH].
- ClearReq  input  1  single-cycle request to start a clear sweep.
- Busy  output  1  high while a sweep is in progress.
- WriteDropped  output  1  registered one-cycle pulse: a write was rejected.

Behaviour:
- Reset (Clk edge with Reset=1):
  - All registers become 0; FSM goes to IDLE; Busy=0; WriteDropped=0.
  - Reset takes priority over ClearReq, over writes, and over an in-progress sweep; a reset mid-sweep aborts it.
- Reads are combinational (zero latency). ReadData[p] = reg[ReadRegister[p]].
- Read ports are fully independent; no port is tied to a fixed address.
- ZERO_REG=1: a read of address 0 returns 0 on every port.
- Write:
  - Occurs on a Clk edge when RegWrite=1, Reset=0 and the FSM is in IDLE.
  - Only reg[WriteRegister] changes; every other entry holds.
  - RegWrite=0 changes no entry.
  - ZERO_REG=1 and WriteRegister=0: write is discarded silently (WriteDropped stays 0).
- BYPASS=1:
  - If RegWrite=1, FSM is IDLE, and ReadRegister[p]==WriteRegister (excluding address 0 when ZERO_REG=1), then ReadData[p]=WriteData in the same cycle.
  - BYPASS=0: the read returns the old value until the edge.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on an edge with ClearReq=1. Index loads FIRST = (ZERO_REG ? 1 : 0); Busy=1 from the next cycle.
  - In SWEEP, each edge clears reg[Index] and increments Index.
  - When Index==DEPTH-1 is cleared, go to IDLE; Busy=0 on the following cycle.
  - Sweep length is DEPTH-FIRST cycles (31 for the defaults).
  - ClearReq while in SWEEP is ignored (no restart). ClearReq and RegWrite on the same IDLE edge: the write lands, then the sweep clears it.
- During SWEEP:
  - RegWrite=1 is rejected: no entry changes, and WriteDropped=1 for the cycle after that edge.
  - Reads return current contents, partially cleared; bypass is disabled.
- Width rules: Index counter is ADDR_W+1 bits so it cannot wrap. No arithmetic on data.

Decomposition:
- Package regfile_pkg: FSM state enum {IDLE, SWEEP}, default WIDTH/DEPTH/NREAD constants, and a function extracting port p's address/data slice.
- Sub-module regfile_clear_seq: owns the FSM, Index counter, Busy and WriteDropped.
  - Outputs clr_en and clr_idx to the array.
  - Outputs wr_allow = (state==IDLE).
- The top-level holds the storage array, write decode, read muxes and bypass.

Test Plan:
- Defaults: write 42 to r2, read r2 on both ports -> 42/42. Write 15 to r2 -> 15/15. Write 17 to r17 and 99 to r9, read port0=r9, port1=r17 -> 99/17; swap addresses -> 17/99. This catches a port stuck on one address.
- RegWrite=0 with WriteData=26 to r3, after r3 was loaded with 7 -> r3 reads 7. Write 23 to r4 after r5 was loaded with 5 -> r4=23, r5=5, r31 unchanged. This catches an ignored enable and a broken decoder.
- ZERO_REG=1: write 19 to r0 -> both ports read 0, WriteDropped=0. ZERO_REG=0: same write -> both ports read 19.
- BYPASS=1: r6=1, then same cycle RegWrite=1, WriteRegister=6, WriteData=0xABCD, read r6 -> 0xABCD before the edge. BYPASS=0 -> 1 before the edge, 0xABCD after.
- Fill r1..r31 with values i; pulse ClearReq -> Busy high for 31 cycles, then all reads 0. A write of 55 to r8 mid-sweep -> WriteDropped pulse, r8=0 at the end. A second ClearReq mid-sweep -> sweep length stays 31.
- Reset asserted at sweep cycle 10 with r20 still holding 20 -> next cycle Busy=0, r20=0. A later write of 3 to r20 -> reads 3.
- NREAD=4, WIDTH=16, DEPTH=8: write 0xFFFF to r7, read all four ports on r7 -> 0xFFFF on each; other ports on r3 -> 0.
